// File: rtl/gate_width_meter.sv
// ============================================================================
// Module      : gate_width_meter
// Description : Measures gate high width and rise-to-rise period in clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_width_meter #(
    parameter int CNT_W       = 4,
    parameter int PER_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate_in,
    output logic [CNT_W-1:0] width_out,
    output logic             width_valid,
    output logic             overflow,
    output logic [PER_W-1:0] period_out,
    output logic             period_valid
);

    localparam logic [CNT_W-1:0] C_WMAX = '1;
    localparam logic [PER_W-1:0] C_PMAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        OVF  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic             r_prev;
    logic             w_s;
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] w_width_nxt;
    logic             r_wvalid;
    logic             w_wvalid_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [PER_W-1:0] r_per_cnt;
    logic [PER_W-1:0] r_period;
    logic             r_pvalid;
    logic             r_first_seen;

    // Chain and previous sample reset high so a gate already high at release
    // produces no rise until it has fallen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gate_in};
            r_prev <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_width  <= '0;
            r_wvalid <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_width  <= w_width_nxt;
            r_wvalid <= w_wvalid_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_width_nxt  = r_width;
        w_wvalid_nxt = 1'b0;
        w_ovf_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = MEAS;
                end
            end
            MEAS: begin
                if (w_s) begin
                    if (r_cnt == C_WMAX) begin
                        w_width_nxt  = C_WMAX;
                        w_wvalid_nxt = 1'b1;
                        w_ovf_nxt    = 1'b1;
                        w_state_nxt  = OVF;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    // s was high last cycle, so low here is the fall
                    w_width_nxt  = r_cnt;
                    w_wvalid_nxt = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            OVF: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt    <= '0;
            r_period     <= '0;
            r_pvalid     <= 1'b0;
            r_first_seen <= 1'b0;
        end else begin
            r_pvalid <= 1'b0;
            if (w_rise) begin
                if (r_first_seen) begin
                    r_period <= r_per_cnt;
                    r_pvalid <= 1'b1;
                end
                r_per_cnt    <= PER_W'(1);
                r_first_seen <= 1'b1;
            end else if (r_per_cnt != C_PMAX) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end
        end
    end

    assign width_out    = r_width;
    assign width_valid  = r_wvalid;
    assign overflow     = r_ovf;
    assign period_out   = r_period;
    assign period_valid = r_pvalid;

endmodule

`default_nettype wire

// File: tb/tb_gate_width_meter.sv
// ============================================================================
// Module      : tb_gate_width_meter
// Description : Scoreboard bench for gate_width_meter with directed gate pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_width_meter;

    localparam int CNT_W = 4;
    localparam int PER_W = 8;

    logic             clk;
    logic             rst_n;
    logic             gate_in;
    logic [CNT_W-1:0] width_out;
    logic             width_valid;
    logic             overflow;
    logic [PER_W-1:0] period_out;
    logic             period_valid;

    int tests;
    int fails;

    // width queue holds {overflow, width}
    logic [CNT_W:0]   wq[$];
    logic [PER_W-1:0] pq[$];

    gate_width_meter #(.CNT_W(CNT_W), .PER_W(PER_W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate_in      (gate_in),
        .width_out    (width_out),
        .width_valid  (width_valid),
        .overflow     (overflow),
        .period_out   (period_out),
        .period_valid (period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_width_out"},    int'(width_out), 0);
        chk({tag, "_width_valid"},  int'(width_valid), 0);
        chk({tag, "_overflow"},     int'(overflow), 0);
        chk({tag, "_period_out"},   int'(period_out), 0);
        chk({tag, "_period_valid"}, int'(period_valid), 0);
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) begin
            @(negedge clk);
            gate_in = 1'b1;
        end
        repeat (lo) begin
            @(negedge clk);
            gate_in = 1'b0;
        end
    endtask

    task automatic exp_w(input int w, input bit ovf);
        wq.push_back({ovf, CNT_W'(w)});
    endtask

    // Monitor: pops the scoreboard whenever a strobe appears
    initial begin
        logic [CNT_W:0] we;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (width_valid) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_width_valid", 1, 0);
                    end else begin
                        we = wq.pop_front();
                        chk("width_out", int'(width_out), int'(we[CNT_W-1:0]));
                        chk("overflow",  int'(overflow),  int'(we[CNT_W]));
                    end
                end else if (overflow) begin
                    chk("overflow_without_valid", 1, 0);
                end
                if (period_valid) begin
                    if (pq.size() == 0) begin
                        chk("unexpected_period_valid", 1, 0);
                    end else begin
                        chk("period_out", int'(period_out), int'(pq.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        gate_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // Gate already high at release: ignored; then a 3-cycle gate
        @(negedge clk);
        rst_n = 1'b1;
        pulse(5, 0);
        pulse(0, 6);
        exp_w(3, 0);
        pulse(3, 17);

        // Widths 1, 7, 15 every 20 cycles
        exp_w(1, 0);  pq.push_back(8'd20);
        pulse(1, 19);
        exp_w(7, 0);  pq.push_back(8'd20);
        pulse(7, 13);
        exp_w(15, 0); pq.push_back(8'd20);
        pulse(15, 5);

        // Long gate overflows once; next gate measures normally
        exp_w(15, 1); pq.push_back(8'd20);
        pulse(40, 10);
        exp_w(4, 0);  pq.push_back(8'd50);
        pulse(4, 6);

        // Single low cycle between gates
        exp_w(3, 0);  pq.push_back(8'd10);
        pulse(3, 1);
        exp_w(2, 0);  pq.push_back(8'd4);
        pulse(2, 8);

        // Period saturation
        exp_w(1, 0);  pq.push_back(8'd10);
        pulse(1, 299);
        exp_w(1, 0);  pq.push_back(8'd255);
        pulse(1, 20);

        // Reset in the middle of a gate
        pq.push_back(8'd21);
        @(negedge clk);
        gate_in = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midgate_reset");
        @(negedge clk);
        rst_n = 1'b1;
        pulse(4, 6);

        // First gate after reset: width only, no period
        exp_w(2, 0);
        pulse(2, 10);

        chk("width_queue_empty",  wq.size(), 0);
        chk("period_queue_empty", pq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
